// File: rtl/traffic_pkg.sv
// Shared types and lamp decode for the two-way traffic light controller.
package traffic_pkg;

    localparam int LIGHT_W = 2;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        WALK      = 3'd6
    } state_e;

    typedef enum logic [LIGHT_W-1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_e;

    // North-south lamp colour shown in a given phase; RED everywhere else.
    function automatic light_e ns_lamp(input state_e s);
        light_e l;
        case (s)
            NS_GREEN:  l = GREEN;
            NS_YELLOW: l = YELLOW;
            default:   l = RED;
        endcase
        return l;
    endfunction

    // East-west lamp colour shown in a given phase; RED everywhere else.
    function automatic light_e ew_lamp(input state_e s);
        light_e l;
        case (s)
            EW_GREEN:  l = GREEN;
            EW_YELLOW: l = YELLOW;
            default:   l = RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_dwell_counter.sv
// Counts ticks spent in the current phase and flags the tick that ends it.
module tick_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [CNT_W-1:0] dur,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

    logic [CNT_W-1:0] dwell_r;

    // The last tick of a phase is the one where dwell has reached dur-1.
    assign expire = tick && (dwell_r == (dur - ONE));

    // Advance dwell on each tick and restart it at zero when the phase ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_r <= ZERO;
        end else if (tick) begin
            if (expire) begin
                dwell_r <= ZERO;
            end else begin
                dwell_r <= dwell_r + ONE;
            end
        end else begin
            dwell_r <= dwell_r;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Tick-paced two-way intersection controller with a pedestrian WALK phase.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               ped_btn,
    output logic [LIGHT_W-1:0] ns_light,
    output logic [LIGHT_W-1:0] ew_light,
    output logic               walk,
    output logic               phase_done
);

    state_e           state_r;
    state_e           next_s;
    logic [CNT_W-1:0] dur_s;
    logic             expire_s;
    logic             enter_walk_s;
    logic             ped_pending_r;
    logic             next_ns_r;

    tick_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .dur    (dur_s),
        .expire (expire_s)
    );

    // Length in ticks of the phase currently held in the state register.
    always_comb begin
        dur_s = CNT_W'(ALLRED_TICKS);
        case (state_r)
            NS_GREEN, EW_GREEN:   dur_s = CNT_W'(GREEN_TICKS);
            NS_YELLOW, EW_YELLOW: dur_s = CNT_W'(YELLOW_TICKS);
            WALK:                 dur_s = CNT_W'(WALK_TICKS);
            default:              dur_s = CNT_W'(ALLRED_TICKS);
        endcase
    end

    // Phase sequencing; a pending request diverts an expiring all-red into WALK.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ALLRED_A: begin
                if (expire_s) next_s = ped_pending_r ? WALK : NS_GREEN;
                else          next_s = state_r;
            end
            NS_GREEN: begin
                if (expire_s) next_s = NS_YELLOW;
                else          next_s = state_r;
            end
            NS_YELLOW: begin
                if (expire_s) next_s = ALLRED_B;
                else          next_s = state_r;
            end
            ALLRED_B: begin
                if (expire_s) next_s = ped_pending_r ? WALK : EW_GREEN;
                else          next_s = state_r;
            end
            EW_GREEN: begin
                if (expire_s) next_s = EW_YELLOW;
                else          next_s = state_r;
            end
            EW_YELLOW: begin
                if (expire_s) next_s = ALLRED_A;
                else          next_s = state_r;
            end
            WALK: begin
                if (expire_s) next_s = next_ns_r ? NS_GREEN : EW_GREEN;
                else          next_s = state_r;
            end
            default: next_s = ALLRED_A;
        endcase
    end

    assign enter_walk_s = (next_s == WALK) && (state_r != WALK);

    // State, request bookkeeping and lamp outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ALLRED_A;
            ped_pending_r <= 1'b0;
            next_ns_r     <= 1'b1;
            ns_light      <= RED;
            ew_light      <= RED;
            walk          <= 1'b0;
            phase_done    <= 1'b0;
        end else begin
            state_r    <= next_s;
            ns_light   <= ns_lamp(next_s);
            ew_light   <= ew_lamp(next_s);
            walk       <= (next_s == WALK);
            phase_done <= (next_s != state_r);

            if ((state_r == WALK) || enter_walk_s) begin
                ped_pending_r <= 1'b0;
            end else if (ped_btn) begin
                ped_pending_r <= 1'b1;
            end else begin
                ped_pending_r <= ped_pending_r;
            end

            if (enter_walk_s) begin
                next_ns_r <= (state_r == ALLRED_A);
            end else begin
                next_ns_r <= next_ns_r;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: phase-table reference model plus directed and random stimulus.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_btn = 1'b0;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic       phase_done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ped_btn    (ped_btn),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .walk       (walk),
        .phase_done (phase_done)
    );

    // Reference model. Phases: 0 allred-a, 1 ns green, 2 ns yellow, 3 allred-b,
    // 4 ew green, 5 ew yellow, 6 walk. m_left counts ticks remaining in the phase.
    int dur_tab  [7] = '{1, 5, 2, 1, 5, 2, 3};
    int ns_tab   [7] = '{0, 2, 1, 0, 0, 0, 0};
    int ew_tab   [7] = '{0, 0, 0, 0, 2, 1, 0};
    int walk_tab [7] = '{0, 0, 0, 0, 0, 0, 1};

    int m_ph     = 0;
    int m_left   = 1;
    bit m_pend   = 1'b0;
    bit m_nsnext = 1'b1;
    bit m_pd     = 1'b0;

    function automatic int succ(input int ph, input bit pend, input bit nsn);
        case (ph)
            0: return pend ? 6 : 1;
            1: return 2;
            2: return 3;
            3: return pend ? 6 : 4;
            4: return 5;
            5: return 0;
            6: return nsn ? 1 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model advance on each clock; reset is immediate like the design's.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph     <= 0;
            m_left   <= 1;
            m_pend   <= 1'b0;
            m_nsnext <= 1'b1;
            m_pd     <= 1'b0;
        end else begin
            if (tick && m_left == 1) begin
                m_ph   <= succ(m_ph, m_pend, m_nsnext);
                m_left <= dur_tab[succ(m_ph, m_pend, m_nsnext)];
                m_pd   <= 1'b1;
                if ((m_ph == 0 || m_ph == 3) && m_pend) m_nsnext <= (m_ph == 0);
            end else begin
                if (tick) m_left <= m_left - 1;
                m_pd <= 1'b0;
            end
            if (m_ph == 6 || (tick && m_left == 1 && succ(m_ph, m_pend, m_nsnext) == 6))
                m_pend <= 1'b0;
            else if (ped_btn)
                m_pend <= 1'b1;
        end
    end

    // Every-cycle comparison against the model plus the lamp safety rules.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("ns_light", int'(ns_light), ns_tab[m_ph]);
            chk("ew_light", int'(ew_light), ew_tab[m_ph]);
            chk("walk", int'(walk), walk_tab[m_ph]);
            chk("phase_done", int'(phase_done), int'(m_pd));
            chk("no_conflict", int'(ns_light != 2'b00 && ew_light != 2'b00), 0);
            chk("walk_all_red", int'(walk && (ns_light != 2'b00 || ew_light != 2'b00)), 0);
        end
    end

    task automatic step(input logic t, input logic p);
        tick    = t;
        ped_btn = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tick    = 1'b0;
        ped_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ns", int'(ns_light), 0);
        chk("rst_ew", int'(ew_light), 0);
        chk("rst_walk", int'(walk), 0);
        chk("rst_pd", int'(phase_done), 0);
        chk_en = 1'b1;

        // Free-running cycle, tick every clk.
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b0);
            if (k <= 16 && phase_done) cnt++;
            if (k == 1)  chk("t1_ns_green", int'(ns_light), 2);
            if (k == 6)  chk("t1_ns_yellow", int'(ns_light), 1);
            if (k == 8)  chk("t1_allred_b", int'(ns_light | ew_light), 0);
            if (k == 9)  chk("t1_ew_green", int'(ew_light), 2);
            if (k == 17) chk("t1_period", int'(ns_light), 2);
        end
        chk("t1_pd_count", cnt, 6);

        // Tick every 4th clk stretches each phase fourfold.
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step(((k - 1) % 4) == 0, 1'b0);
            if (ns_light == 2'b10) cnt++;
            if (k == 21) chk("t2_ns_yellow", int'(ns_light), 1);
        end
        chk("t2_green_clks", cnt, 20);

        // Single press during NS green: one WALK after allred-b, then EW green.
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, k == 3);
            if (walk) cnt++;
            if (k == 9)  chk("t3_walk", int'(walk), 1);
            if (k == 12) chk("t3_ew_after", int'(ew_light), 2);
        end
        chk("t3_walk_clks", cnt, 3);

        // Button held across WALK: re-latches after exit, second WALK from allred-a.
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 26; k++) begin
            step(1'b1, k >= 3 && k <= 13);
            if (walk) cnt++;
            if (k == 12) chk("t4_walk_exit", int'(walk), 0);
            if (k == 20) chk("t4_walk2", int'(walk), 1);
            if (k == 23) chk("t4_ns_after", int'(ns_light), 2);
        end
        chk("t4_walk_clks", cnt, 6);

        // Asynchronous reset in the middle of NS yellow.
        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, 1'b0);
        chk("t5_pre_yellow", int'(ns_light), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_ns", int'(ns_light), 0);
        chk("t5_async_ew", int'(ew_light), 0);
        chk("t5_async_walk", int'(walk), 0);
        chk("t5_async_pd", int'(phase_done), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0);
        chk("t5_restart_ns", int'(ns_light), 2);
        chk("t5_restart_pd", int'(phase_done), 1);

        // Random ticks and presses against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
